// File: rtl/int_pipe_ctrl_if.sv
// Pipeline-control bundle between the fetch/decode pipeline and the
// interrupt sequencer; master drives requests, slave returns controls.
interface int_pipe_ctrl_if;
    logic        irq;
    logic        irq_en;
    logic        hazard_stall;
    logic        branch_taken;
    logic        eret;
    logic [31:0] if_pc;
    logic        staller;
    logic        flush;
    logic        iack;
    logic [1:0]  pc_sel;
    logic [31:0] epc;
    logic        in_isr;

    modport master (
        output irq, irq_en, hazard_stall, branch_taken, eret, if_pc,
        input  staller, flush, iack, pc_sel, epc, in_isr
    );

    modport slave (
        input  irq, irq_en, hazard_stall, branch_taken, eret, if_pc,
        output staller, flush, iack, pc_sel, epc, in_isr
    );
endinterface

// File: rtl/int_pipe_ctrl.sv
// Interrupt entry/exit sequencer for the IF/ID register and PC source:
// drains the pipe, vectors to the handler, saves and restores EPC.
module int_pipe_ctrl #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0080,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    int_pipe_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2,
        ISR   = 2'd3
    } state_t;

    localparam logic [1:0] PC_NORM = 2'd0;
    localparam logic [1:0] PC_HOLD = 2'd1;
    localparam logic [1:0] PC_VEC  = 2'd2;
    localparam logic [1:0] PC_EPC  = 2'd3;
    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic        isr_q, isr_d;

    logic        staller;
    logic        flush;
    logic        iack;
    logic [1:0]  pc_sel;
    logic        take;

    // Entry is deferred while the pipe is stalled or redirecting, so EPC
    // always names the instruction that will really execute next.
    assign take = bus.irq && bus.irq_en &&
                  !bus.hazard_stall && !bus.branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            epc_q   <= '0;
            isr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            isr_q   <= isr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        isr_d   = isr_q;
        staller = 1'b0;
        flush   = 1'b0;
        iack    = 1'b0;
        pc_sel  = PC_NORM;

        unique case (state_q)
            IDLE: begin
                staller = bus.hazard_stall;
                flush   = bus.branch_taken;
                if (take) begin
                    epc_d   = bus.if_pc;
                    cnt_d   = CNT_INIT;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                flush  = 1'b1;
                pc_sel = PC_HOLD;
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                iack    = 1'b1;
                pc_sel  = PC_VEC;
                isr_d   = 1'b1;
                state_d = ISR;
            end
            ISR: begin
                staller = bus.hazard_stall;
                flush   = bus.branch_taken;
                if (bus.eret && !bus.hazard_stall) begin
                    pc_sel  = PC_EPC;
                    flush   = 1'b1;
                    isr_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            staller = 1'b0;
            flush   = 1'b0;
            iack    = 1'b0;
            pc_sel  = PC_NORM;
        end
    end

    assign bus.staller = staller;
    assign bus.flush   = flush;
    assign bus.iack    = iack;
    assign bus.pc_sel  = pc_sel;
    assign bus.epc     = epc_q;
    assign bus.in_isr  = isr_q;

    // The handler address is consumed by the PC mux outside this block.
    logic unused_vec;
    assign unused_vec = ^VECTOR_ADDR;

endmodule

// File: tb/tb_int_pipe_ctrl.sv
// Directed bench for int_pipe_ctrl: per-cycle vector table plus
// hand-written reset-abort and re-entry sequence.
module tb_int_pipe_ctrl;

    localparam int DC = 3;

    logic clk;
    logic reset;

    int_pipe_ctrl_if bus ();

    int_pipe_ctrl #(
        .VECTOR_ADDR  (32'h0000_0080),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        irq;
        logic        en;
        logic        hs;
        logic        bt;
        logic        er;
        logic [31:0] pc;
        logic        e_st;
        logic        e_fl;
        logic        e_ia;
        logic [1:0]  e_ps;
        logic [31:0] e_epc;
        logic        e_isr;
    } vec_t;

    vec_t vec [27];
    int   n_chk;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic irq, input logic en,
                         input logic hs, input logic bt, input logic er,
                         input logic [31:0] pc);
        reset            = rst;
        bus.irq          = irq;
        bus.irq_en       = en;
        bus.hazard_stall = hs;
        bus.branch_taken = bt;
        bus.eret         = er;
        bus.if_pc        = pc;
    endtask

    task automatic chk_all(input string tag, input logic st,
                           input logic fl, input logic ia,
                           input logic [1:0] ps, input logic [31:0] epc,
                           input logic isr);
        chk({tag, " staller"}, 32'(bus.staller), 32'(st));
        chk({tag, " flush"},   32'(bus.flush),   32'(fl));
        chk({tag, " iack"},    32'(bus.iack),    32'(ia));
        chk({tag, " pc_sel"},  32'(bus.pc_sel),  32'(ps));
        chk({tag, " epc"},     bus.epc,          epc);
        chk({tag, " in_isr"},  32'(bus.in_isr),  32'(isr));
    endtask

    initial begin
        int  found;
        int  lat;

        n_chk  = 0;
        n_fail = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40);

        //         rst  irq  en   hs   bt   er   pc      st   fl   ia   ps    epc     isr
        vec[0]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'h40, 1'b0,1'b0,1'b0,2'd0,32'h0,  1'b0};
        vec[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'h40, 1'b0,1'b0,1'b0,2'd0,32'h0,  1'b0};
        vec[2]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,32'h40, 1'b0,1'b0,1'b0,2'd0,32'h0,  1'b0};
        vec[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h40, 1'b1,1'b0,1'b0,2'd0,32'h0,  1'b0};
        vec[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,32'h40, 1'b0,1'b1,1'b0,2'd0,32'h0,  1'b0};
        vec[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h40, 1'b0,1'b0,1'b0,2'd0,32'h0,  1'b0};
        vec[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h44, 1'b0,1'b0,1'b0,2'd0,32'h0,  1'b0};
        vec[7]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h100,1'b0,1'b0,1'b0,2'd0,32'h0,  1'b0};
        vec[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h104,1'b0,1'b1,1'b0,2'd1,32'h100,1'b0};
        vec[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h104,1'b0,1'b1,1'b0,2'd1,32'h100,1'b0};
        vec[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h104,1'b0,1'b1,1'b0,2'd1,32'h100,1'b0};
        vec[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h104,1'b0,1'b0,1'b1,2'd2,32'h100,1'b0};
        vec[12] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h80, 1'b0,1'b0,1'b0,2'd0,32'h100,1'b1};
        vec[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h84, 1'b0,1'b0,1'b0,2'd0,32'h100,1'b1};
        vec[14] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h88, 1'b1,1'b0,1'b0,2'd0,32'h100,1'b1};
        vec[15] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h88, 1'b1,1'b0,1'b0,2'd0,32'h100,1'b1};
        vec[16] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h88, 1'b0,1'b1,1'b0,2'd3,32'h100,1'b1};
        vec[17] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h104,1'b0,1'b0,1'b0,2'd0,32'h100,1'b0};
        vec[18] = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,32'h200,1'b0,1'b1,1'b0,2'd0,32'h100,1'b0};
        vec[19] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h300,1'b0,1'b0,1'b0,2'd0,32'h100,1'b0};
        vec[20] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h304,1'b0,1'b1,1'b0,2'd1,32'h300,1'b0};
        vec[21] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h304,1'b0,1'b1,1'b0,2'd1,32'h300,1'b0};
        vec[22] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h304,1'b0,1'b1,1'b0,2'd1,32'h300,1'b0};
        vec[23] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h304,1'b0,1'b0,1'b1,2'd2,32'h300,1'b0};
        vec[24] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,32'h80, 1'b0,1'b1,1'b0,2'd3,32'h300,1'b1};
        vec[25] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h304,1'b0,1'b0,1'b0,2'd0,32'h300,1'b0};
        vec[26] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'h308,1'b0,1'b0,1'b0,2'd0,32'h300,1'b0};

        for (int i = 0; i < 27; i++) begin
            drive(vec[i].rst, vec[i].irq, vec[i].en, vec[i].hs,
                  vec[i].bt, vec[i].er, vec[i].pc);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), vec[i].e_st, vec[i].e_fl,
                    vec[i].e_ia, vec[i].e_ps, vec[i].e_epc, vec[i].e_isr);
            @(posedge clk);
            #1;
        end

        // Take at 0x500, then reset on the second drain cycle.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h504);
        @(negedge clk);
        chk_all("drain1", 1'b0, 1'b1, 1'b0, 2'd1, 32'h500, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h504);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_all($sformatf("rst_abort%0d", i),
                    1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h504);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_all($sformatf("post_rst%0d", i),
                    1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
            @(posedge clk); #1;
        end

        // Fresh entry after the abort: iack must land DC cycles after take.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h604);
        found = 0;
        lat   = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            @(negedge clk);
            if (bus.iack === 1'b1) begin
                found = 1;
                lat   = i;
            end
            @(posedge clk); #1;
        end
        chk("reentry iack seen", 32'(found), 32'd1);
        chk("reentry latency", 32'(lat), 32'(DC));
        chk("reentry epc", bus.epc, 32'h600);
        chk("reentry in_isr", 32'(bus.in_isr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int_pipe_ctrl.md
Name: int_pipe_ctrl

Overview:
- Sequences the IF/ID pipeline register and PC source for external interrupts and exception return.
- Sits beside the fetch stage and drives:
  - the IF/ID stall input (staller);
  - the IF/ID flush input;
  - the IACK bit carried by the IF/ID register;
  - the PC-source select.
- Merges hazard-unit stalls and branch flushes with interrupt entry and exit, and holds the saved return PC (EPC).

Parameters:
- VECTOR_ADDR, 32'h0000_0080, PC of the interrupt service routine.
- DRAIN_CYCLES, 3, number of bubble cycles injected before vectoring. Range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq  input  1  level interrupt request.
- irq_en  input  1  global interrupt enable from the status register.
- hazard_stall  input  1  load-use stall request from the hazard unit.
- branch_taken  input  1  branch resolved taken in ID; the IF/ID contents must be flushed.
- eret  input  1  ERET decoded in ID.
- if_pc  input  32  PC of the instruction currently in IF.
- staller  output  1  IF/ID and PC hold.
- flush  output  1  IF/ID loads a NOP (32'h0) instead of fetched data.
- iack  output  1  interrupt acknowledge; fed to IF/ID IACK_in.
- pc_sel  output  2  PC source: 0 = PC+4 / branch (normal), 1 = hold, 2 = VECTOR_ADDR, 3 = epc.
- epc  output  32  saved return PC.
- in_isr  output  1  high while the handler is executing.

Behaviour:
- Reset:
  - While reset is high: state = IDLE, drain counter = 0, epc = 0, in_isr = 0.
  - All combinational outputs are forced to 0: staller, flush, iack, and pc_sel = 0.
  - Reset asserted mid-sequence (DRAIN, ACK or ISR) aborts the sequence immediately. No iack is issued afterwards.
- Output timing:
  - Outputs are combinational from the registered state plus the current inputs.
  - epc and in_isr are registered.
- IDLE state:
  - staller = hazard_stall, flush = branch_taken, pc_sel = 0, iack = 0.
  - Interrupt take condition: irq && irq_en && !hazard_stall && !branch_taken.
  - When the take condition holds: epc <= if_pc, counter <= DRAIN_CYCLES-1, next state = DRAIN.
  - An irq coincident with hazard_stall or branch_taken is deferred. It is re-evaluated every cycle, so EPC captures the post-branch / post-stall PC.
- DRAIN state:
  - flush = 1, pc_sel = 1 (hold), staller = 0. Older instructions retire while bubbles enter ID.
  - hazard_stall and branch_taken are ignored, since no younger instruction exists.
  - Counter decrements each cycle. When the counter is 0: next state = ACK.
  - irq deasserting during DRAIN does not cancel; entry is committed once DRAIN is entered.
- ACK state (exactly 1 cycle):
  - iack = 1, pc_sel = 2, flush = 0, staller = 0.
  - in_isr <= 1. Next state = ISR.
  - IF/ID captures IACK = 1 alongside the first handler fetch on the following edge.
- ISR state:
  - staller = hazard_stall, flush = branch_taken, pc_sel = 0.
  - irq is ignored; there is no nesting, regardless of irq_en.
  - eret && !hazard_stall: pc_sel = 3, flush = 1, in_isr <= 0, next state = IDLE.
  - eret while hazard_stall is high waits until the stall drops.
  - eret and branch_taken together: eret wins (pc_sel = 3, flush = 1).
- eret seen in IDLE: ignored (treated as NOP), outputs follow the IDLE rules.
- epc holds its value from capture until the next capture or reset.
- Total interrupt latency is DRAIN_CYCLES + 2 cycles: the take edge, then DRAIN_CYCLES cycles, then ACK, then the first vector fetch registered in IF/ID.

Test Plan:
- Reset check: apply reset = 1 for 3 cycles with irq = 1, hazard_stall = 1, if_pc = 32'h40 -> staller = 0, flush = 0, iack = 0, pc_sel = 0, epc = 0, in_isr = 0 throughout.
- Basic entry: irq_en = 1; pulse irq at if_pc = 32'h0000_0100 -> epc = 32'h100; flush = 1 and pc_sel = 1 for 3 cycles; then 1 cycle with iack = 1, pc_sel = 2; in_isr = 1 on the following cycle.
- Deferred entry: irq = 1 with branch_taken = 1 at if_pc = 32'h200, next cycle if_pc = 32'h300 -> entry deferred one cycle, epc = 32'h300.
- ISR masking and return: in ISR, pulse irq -> no new DRAIN. Assert eret with hazard_stall = 1 for 2 cycles, then 0 -> pc_sel = 3 and flush = 1 only on the third cycle; in_isr = 0 and state back to IDLE afterwards.
- Pass-through: in IDLE assert hazard_stall -> staller = 1. In IDLE assert branch_taken -> flush = 1. With irq_en = 0 and irq = 1 -> no entry, iack stays 0.
- Reset mid-DRAIN: assert reset on the 2nd DRAIN cycle -> iack never asserts, epc = 0, IDLE on release; a new irq afterwards enters normally.
